uart_rx_fifo: RTL and testbench

Parametrised next-generation UART receiver with runtime-configurable baud divisor, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote, and break conditions are detected. Received words are buffered in an internal first-word-fall-through (FWFT) FIFO with a ready/valid output. It sits between the pad-level RX line and the bus-side UART peripheral registers.

---
 rtl/uart_rx_fifo.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with 3-sample majority voting, break detection
// and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_rxd,
   input  logic [DIV_WIDTH-1:0]            i_div,
   input  logic [1:0]                      i_parity,
   input  logic                            i_stop2,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [$clog2(FIFO_DEPTH):0]     o_count,
   output logic                            o_busy,
   output logic                            o_parity_error,
   output logic                            o_frame_error,
   output logic                            o_overrun_error,
   output logic                            o_break
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(DATA_WIDTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic                  sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
   logic [2:0]            state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
   logic [IW-1:0]         bit_idx_q, bit_idx_d;
   logic                  stop_idx_q, stop_idx_d;
   logic [1:0]            smp_q, smp_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_bit_q, par_bit_d, par_bad_q, par_bad_d;
   logic                  stop_bad_q, stop_bad_d, brk_wait_q, brk_wait_d;
   logic [1:0]            par_mode_q, par_mode_d;
   logic                  stop2_q, stop2_d;
   logic                  pe_q, pe_d, fe_q, fe_d, ov_q, ov_d, brk_q, brk_d;
   logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                  rxd_s, fall, vote, par_en, sbad;
   logic                  at_h_m1, at_h, at_h_p1, at_end;
   logic [DIV_WIDTH-1:0]  half;
   logic                  push, pop, full, empty, wr;

   assign rxd_s   = sync2_q;
   assign fall    = dly_q & ~sync2_q;
   assign half    = div_q >> 1;
   assign at_h_m1 = (cnt_q == half - DIV_WIDTH'(1));
   assign at_h    = (cnt_q == half);
   assign at_h_p1 = (cnt_q == half + DIV_WIDTH'(1));
   assign at_end  = (cnt_q == div_q - DIV_WIDTH'(1));
   assign vote    = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxd_s) | (smp_q[0] & rxd_s);
   assign par_en  = (par_mode_q == 2'd1) || (par_mode_q == 2'd2);
   assign sbad    = stop_bad_q | ~vote;

   always_comb begin
      sync1_d    = i_rxd;
      sync2_d    = sync1_q;
      dly_d      = sync2_q;
      state_d    = state_q;
      cnt_d      = at_end ? '0 : cnt_q + DIV_WIDTH'(1);
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      smp_d      = smp_q;
      data_d     = data_q;
      par_bit_d  = par_bit_q;
      par_bad_d  = par_bad_q;
      stop_bad_d = stop_bad_q;
      brk_wait_d = brk_wait_q;
      par_mode_d = par_mode_q;
      stop2_d    = stop2_q;
      pe_d       = 1'b0;
      fe_d       = 1'b0;
      brk_d      = 1'b0;
      push       = 1'b0;

      if (at_h_m1) smp_d[1] = rxd_s;
      if (at_h)    smp_d[0] = rxd_s;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // After a break the line must return high before a new start edge counts.
            if (brk_wait_q) begin
               if (rxd_s) brk_wait_d = 1'b0;
            end else if (fall) begin
               state_d    = S_START;
               div_d      = i_div;
               par_mode_d = i_parity;
               stop2_d    = i_stop2;
               data_d     = '0;
               par_bit_d  = 1'b0;
               par_bad_d  = 1'b0;
               stop_bad_d = 1'b0;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
            end
         end
         S_START: begin
            if (at_h_p1 && vote) begin
               fe_d    = 1'b1;
               state_d = S_IDLE;
            end else if (at_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            if (at_h_p1) data_d[bit_idx_q] = vote;
            if (at_end) begin
               if (bit_idx_q == IW'(DATA_WIDTH - 1)) begin
                  state_d    = par_en ? S_PARITY : S_STOP;
                  stop_idx_d = 1'b0;
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
               end
            end
         end
         S_PARITY: begin
            if (at_h_p1) begin
               par_bit_d = vote;
               par_bad_d = (par_mode_q == 2'd1) ? ((^data_q) != vote) : ((^data_q) == vote);
            end
            if (at_end) state_d = S_STOP;
         end
         S_STOP: begin
            // Complete mid-way through the last stop bit so a following start edge is not missed.
            if (at_h_p1) begin
               if (stop_idx_q == stop2_q) begin
                  state_d = S_IDLE;
                  if (sbad) begin
                     if ((data_q == '0) && !par_bit_q) begin
                        brk_d      = 1'b1;
                        brk_wait_d = 1'b1;
                     end else begin
                        fe_d = 1'b1;
                     end
                  end else if (par_bad_q) begin
                     pe_d = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end else begin
                  stop_bad_d = sbad;
               end
            end else if (at_end) begin
               stop_idx_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign pop   = !empty && i_ready;
   assign wr    = push && (!full || pop);

   always_comb begin
      ov_d    = push && full && !pop;
      wptr_d  = wptr_q + AW'(wr);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + CW'(wr) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         dly_q      <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         smp_q      <= '0;
         data_q     <= '0;
         par_bit_q  <= 1'b0;
         par_bad_q  <= 1'b0;
         stop_bad_q <= 1'b0;
         brk_wait_q <= 1'b0;
         par_mode_q <= '0;
         stop2_q    <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         ov_q       <= 1'b0;
         brk_q      <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         dly_q      <= dly_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         smp_q      <= smp_d;
         data_q     <= data_d;
         par_bit_q  <= par_bit_d;
         par_bad_q  <= par_bad_d;
         stop_bad_q <= stop_bad_d;
         brk_wait_q <= brk_wait_d;
         par_mode_q <= par_mode_d;
         stop2_q    <= stop2_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
         ov_q       <= ov_d;
         brk_q      <= brk_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= data_q;
   end

   assign o_data          = empty ? '0 : mem_q[rptr_q];
   assign o_valid         = !empty;
   assign o_count         = count_q;
   assign o_busy          = (state_q != S_IDLE);
   assign o_parity_error  = pe_q;
   assign o_frame_error   = fe_q;
   assign o_overrun_error = ov_q;
   assign o_break         = brk_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo: framing, parity, FIFO
// overrun, glitch rejection, break and reset behaviour.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rxd;
   logic [15:0] i_div;
   logic [1:0]  i_parity;
   logic        i_stop2;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        i_ready;
   logic [4:0]  o_count;
   logic        o_busy;
   logic        o_parity_error;
   logic        o_frame_error;
   logic        o_overrun_error;
   logic        o_break;

   uart_rx_fifo #(.DATA_WIDTH(8), .DIV_WIDTH(16), .FIFO_DEPTH(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_rxd           (i_rxd),
      .i_div           (i_div),
      .i_parity        (i_parity),
      .i_stop2         (i_stop2),
      .o_data          (o_data),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_count         (o_count),
      .o_busy          (o_busy),
      .o_parity_error  (o_parity_error),
      .o_frame_error   (o_frame_error),
      .o_overrun_error (o_overrun_error),
      .o_break         (o_break)
   );

   initial forever #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int pe_n = 0, fe_n = 0, ov_n = 0, brk_n = 0, max_cnt = 0;
   logic [7:0] rq[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (o_parity_error)  pe_n++;
      if (o_frame_error)   fe_n++;
      if (o_overrun_error) ov_n++;
      if (o_break)         brk_n++;
      if (o_valid && i_ready) rq.push_back(o_data);
      if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
   end

   // pbit < 0: no parity bit; stops[0] is the first stop bit; glitch_at inverts one line cycle;
   // new_div > 0 is applied to i_div once the start bit has been driven.
   task automatic send_frame(input logic [7:0] d, input int per, input int pbit,
                             input logic [1:0] stops, input int nstop,
                             input int glitch_at, input int new_div);
      logic [15:0] bv;
      int nb;
      int j;
      bv = '0;
      for (int i = 0; i < 8; i++) bv[1 + i] = d[i];
      nb = 9;
      if (pbit >= 0) begin
         bv[nb] = pbit[0];
         nb++;
      end
      for (int s = 0; s < nstop; s++) begin
         bv[nb] = stops[s];
         nb++;
      end
      j = 0;
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < per; c++) begin
            if (new_div > 0 && j == per) i_div = new_div[15:0];
            i_rxd = bv[b] ^ (j == glitch_at);
            tick();
            j++;
         end
      end
      i_rxd = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      rst      = 1'b1;
      i_rxd    = 1'b1;
      i_div    = 16'd8;
      i_parity = 2'd0;
      i_stop2  = 1'b0;
      i_ready  = 1'b1;
      repeat (3) tick();
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_count", o_count, 0);
      check_eq("rst_data", o_data, 0);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_errs", {o_parity_error, o_frame_error, o_overrun_error, o_break}, 0);
      rst = 1'b0;
      repeat (4) tick();

      // Plain 8N1 frames
      send_frame(8'h55, 8, -1, 2'b11, 1, -1, 0);
      send_frame(8'hA3, 8, -1, 2'b11, 1, -1, 0);
      repeat (4) tick();
      check_eq("t1_nrx", rq.size(), 2);
      check_eq("t1_w0", rq[0], 8'h55);
      check_eq("t1_w1", rq[1], 8'hA3);
      check_eq("t1_maxcnt_le1", max_cnt <= 1, 1);
      check_eq("t1_errs", pe_n + fe_n + ov_n + brk_n, 0);

      // Even then odd parity
      i_parity = 2'd1;
      send_frame(8'h07, 8, 1, 2'b11, 1, -1, 0);
      send_frame(8'h07, 8, 0, 2'b11, 1, -1, 0);
      check_eq("t2_even_pe", pe_n, 1);
      i_parity = 2'd2;
      send_frame(8'h07, 8, 0, 2'b11, 1, -1, 0);
      send_frame(8'h07, 8, 1, 2'b11, 1, -1, 0);
      repeat (4) tick();
      check_eq("t2_nrx", rq.size(), 4);
      check_eq("t2_w2", rq[2], 8'h07);
      check_eq("t2_w3", rq[3], 8'h07);
      check_eq("t2_pe", pe_n, 2);
      check_eq("t2_fe", fe_n, 0);

      // Fill the FIFO past full
      i_parity = 2'd0;
      i_ready  = 1'b0;
      for (int k = 0; k < 17; k++) send_frame(k[7:0], 8, -1, 2'b11, 1, -1, 0);
      check_eq("t3_count_full", o_count, 16);
      check_eq("t3_ovr", ov_n, 1);
      check_eq("t3_head", o_data, 8'h00);
      i_ready = 1'b1;
      repeat (24) tick();
      check_eq("t3_nrx", rq.size(), 20);
      for (int k = 0; k < 16; k++) check_eq($sformatf("t3_drain%0d", k), rq[4 + k], k);
      check_eq("t3_count_empty", o_count, 0);

      // Single-sample glitch in data bit 3, then a short low pulse on idle line
      send_frame(8'h00, 8, -1, 2'b11, 1, 37, 0);
      check_eq("t4_fe_none", fe_n, 0);
      i_rxd = 1'b0;
      tick();
      tick();
      i_rxd = 1'b1;
      repeat (16) tick();
      check_eq("t4_nrx", rq.size(), 21);
      check_eq("t4_w", rq[20], 8'h00);
      check_eq("t4_fe_glitch", fe_n, 1);
      check_eq("t4_busy", o_busy, 0);

      // Two stop bits with a bad second one, then a break
      i_stop2 = 1'b1;
      send_frame(8'h3C, 8, -1, 2'b01, 2, -1, 0);
      check_eq("t5_fe", fe_n, 2);
      check_eq("t5_nrx", rq.size(), 21);
      i_rxd = 1'b0;
      repeat (96) tick();
      check_eq("t5_brk", brk_n, 1);
      check_eq("t5_fe_after_brk", fe_n, 2);
      check_eq("t5_busy_low", o_busy, 0);
      check_eq("t5_count", o_count, 0);
      i_rxd = 1'b1;
      repeat (4) tick();
      send_frame(8'h5A, 8, -1, 2'b11, 2, -1, 0);
      repeat (4) tick();
      check_eq("t5_nrx2", rq.size(), 22);
      check_eq("t5_w", rq[21], 8'h5A);
      check_eq("t5_brk_once", brk_n, 1);

      // Divisor change mid-frame, then reset mid-frame
      i_stop2 = 1'b0;
      i_ready = 1'b0;
      i_div   = 16'd8;
      send_frame(8'h96, 8, -1, 2'b11, 1, -1, 16);
      check_eq("t6_count1", o_count, 1);
      check_eq("t6_head", o_data, 8'h96);
      i_rxd = 1'b0;
      repeat (40) tick();
      check_eq("t6_busy_mid", o_busy, 1);
      rst   = 1'b1;
      i_rxd = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_eq("t6_rst_busy", o_busy, 0);
      check_eq("t6_rst_count", o_count, 0);
      check_eq("t6_rst_valid", o_valid, 0);
      check_eq("t6_rst_data", o_data, 0);
      repeat (4) tick();
      i_ready = 1'b1;
      send_frame(8'hC3, 16, -1, 2'b11, 1, -1, 0);
      repeat (4) tick();
      check_eq("t6_nrx", rq.size(), 23);
      check_eq("t6_w", rq[22], 8'hC3);
      check_eq("t6_pe_total", pe_n, 2);
      check_eq("t6_fe_total", fe_n, 2);
      check_eq("t6_ov_total", ov_n, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
